// File: rtl/divider_n_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : divider_n_seq_if
// Brief    : Operand/result handshake bundle for the sequential divider.
//            The producer/consumer side uses master; the divider uses slave.
// Revision : 1.0  initial release
// ============================================================================
interface divider_n_seq_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div0;

    modport master (
        output in_valid,
        output dividend,
        output divisor,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  quotient,
        input  remainder,
        input  div0
    );

    modport slave (
        input  in_valid,
        input  dividend,
        input  divisor,
        input  out_ready,
        output in_ready,
        output out_valid,
        output quotient,
        output remainder,
        output div0
    );
endinterface
`default_nettype wire

// File: rtl/divider_n_seq.sv
`default_nettype none
// ============================================================================
// Module   : divider_n_seq
// Brief    : Multi-cycle unsigned restoring divider, one quotient bit per
//            cycle. Define DIVIDER_DIV0_ERR_EN for early divide-by-zero exit.
// Revision : 1.0  initial release
// ============================================================================
module divider_n_seq #(
    parameter int N = 32
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    divider_n_seq_if.slave bus
);

    localparam int            CW     = $clog2(N + 1);
    localparam logic [CW-1:0] c_last = CW'(N - 1);
    localparam logic [CW-1:0] c_one  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [N-1:0]  r_q;
    logic [N-1:0]  r_d;
    logic [N:0]    r_r;
    logic [CW-1:0] r_cnt;

    logic [N:0]    w_t;
    logic [N+1:0]  w_sum;
    logic          w_carry;
    logic          w_done;
    logic          w_div0;
    logic          w_unused_rtop;

    // Subtract as an add of the inverted divisor with carry-in 1; carry-out
    // set means the shifted partial remainder was >= divisor.
    assign w_t     = {r_r[N-1:0], r_q[N-1]};
    assign w_sum   = {1'b0, w_t} + {1'b0, ~{1'b0, r_d}} + {{(N+1){1'b0}}, 1'b1};
    assign w_carry = w_sum[N+1];

    // The partial remainder always stays below the divisor, so its top bit
    // is structurally zero and never feeds the next step.
    assign w_unused_rtop = r_r[N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == c_last) begin
                    w_next = S_DONE;
                end
`ifdef DIVIDER_DIV0_ERR_EN
                if (r_d == '0) begin
                    w_next = S_DONE;
                end
`endif
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= '0;
            r_d   <= '0;
            r_r   <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_q   <= bus.dividend;
                        r_d   <= bus.divisor;
                        r_r   <= '0;
                        r_cnt <= '0;
                    end
                end
                S_BUSY: begin
`ifdef DIVIDER_DIV0_ERR_EN
                    // Zero divisor: jump straight to the natural restoring result.
                    if (r_d == '0) begin
                        r_q <= '1;
                        r_r <= {1'b0, r_q};
                    end else
`endif
                    begin
                        r_q   <= {r_q[N-2:0], w_carry};
                        r_r   <= w_carry ? w_sum[N:0] : w_t;
                        r_cnt <= r_cnt + c_one;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DIVIDER_DIV0_ERR_EN
    logic r_div0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div0 <= 1'b0;
        end else if (r_state == S_IDLE && bus.in_valid) begin
            r_div0 <= 1'b0;
        end else if (r_state == S_BUSY && r_d == '0) begin
            r_div0 <= 1'b1;
        end
    end

    assign w_div0 = r_div0;
`else
    assign w_div0 = 1'b0;
`endif

    assign w_done        = (r_state == S_DONE);
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = w_done;
    assign bus.quotient  = w_done ? r_q : '0;
    assign bus.remainder = w_done ? r_r[N-1:0] : '0;
    assign bus.div0      = w_done & w_div0;

endmodule
`default_nettype wire
